fifo_rd_stream: RTL and testbench

Read-side drain stage placed directly downstream of the async FIFO in the read clock domain. Pops words from the FIFO read port (empty flag, increment strobe, head-of-queue data) and re-presents them on a registered valid/ready stream through a 2-entry output buffer. The buffer decouples downstream backpressure from the FIFO pointer logic and sustains one word per cycle.

---
 rtl/fifo_rd_pkg.sv | 18 +
 rtl/fifo_rd_stream_stats.sv | 40 ++++
 rtl/fifo_rd_stream.sv | 95 +++++++++
 tb/tb_fifo_rd_stream.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rd_pkg.sv
// fifo_rd_pkg: shared constants and helpers for the FIFO read-side drain stage.
//   RD_BUF_DEPTH : entries in the output skid buffer
//   RD_OCC_W     : width of the occupancy count (0..RD_BUF_DEPTH)
//   RD_STAT_W    : width of the optional statistics counters
//   sat_inc()    : increment that sticks at all-ones
package fifo_rd_pkg;

  localparam int RD_BUF_DEPTH = 2;
  localparam int RD_OCC_W     = 2;
  localparam int RD_STAT_W    = 32;

  localparam logic [RD_OCC_W-1:0] RD_OCC_FULL = RD_OCC_W'(RD_BUF_DEPTH);

  function automatic logic [RD_STAT_W-1:0] sat_inc(input logic [RD_STAT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/fifo_rd_stream_stats.sv
// fifo_rd_stats: pair of saturating event counters for the drain stage.
//   rclk      in  read-domain clock
//   rrst_n    in  synchronous active-low reset
//   hs_i      in  handshake this cycle (valid & ready)
//   stall_i   in  stall this cycle (valid & !ready)
//   words_o   out saturating handshake count
//   stall_o   out saturating stall-cycle count
module fifo_rd_stats
  import fifo_rd_pkg::*;
(
  input  logic                 rclk,
  input  logic                 rrst_n,
  input  logic                 hs_i,
  input  logic                 stall_i,
  output logic [RD_STAT_W-1:0] words_o,
  output logic [RD_STAT_W-1:0] stall_o
);

  logic [RD_STAT_W-1:0] words_q, words_d;
  logic [RD_STAT_W-1:0] stall_q, stall_d;

  always_comb begin
    words_d = hs_i    ? sat_inc(words_q) : words_q;
    stall_d = stall_i ? sat_inc(stall_q) : stall_q;
  end

  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      words_q <= '0;
      stall_q <= '0;
    end else begin
      words_q <= words_d;
      stall_q <= stall_d;
    end
  end

  assign words_o = words_q;
  assign stall_o = stall_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: drains the async FIFO read port into a registered
// valid/ready stream through a 2-entry buffer, one word per cycle.
//   rclk       in  read-domain clock
//   rrst_n     in  synchronous active-low reset
//   rempty_i   in  FIFO empty flag (rclk domain)
//   rdata_i    in  FIFO head word, valid while !rempty_i
//   rincr_o    out FIFO pop strobe
//   m_valid_o  out output word valid
//   m_data_o   out output word
//   m_ready_i  in  downstream accept
//   flush_i    in  discard buffered words on the next edge
//   occ_o      out buffer occupancy 0..2
// Optional (macro FIFO_RD_STATS_EN):
//   words_o    out saturating handshake count
//   stall_o    out saturating valid-and-not-ready cycle count
module fifo_rd_stream
  import fifo_rd_pkg::*;
#(
  parameter int DATA_LEN = 32
) (
  input  logic                 rclk,
  input  logic                 rrst_n,
  input  logic                 rempty_i,
  input  logic [DATA_LEN-1:0]  rdata_i,
  output logic                 rincr_o,
  output logic                 m_valid_o,
  output logic [DATA_LEN-1:0]  m_data_o,
  input  logic                 m_ready_i,
  input  logic                 flush_i,
  output logic [RD_OCC_W-1:0]  occ_o
`ifdef FIFO_RD_STATS_EN
  ,
  output logic [RD_STAT_W-1:0] words_o,
  output logic [RD_STAT_W-1:0] stall_o
`endif
);

  logic [RD_BUF_DEPTH-1:0][DATA_LEN-1:0] mem_q;
  logic                                  wptr_q, rptr_q;
  logic [RD_OCC_W-1:0]                   occ_q, occ_d;
  logic                                  push, pop;

  // Pop decision looks only at FIFO state and our own occupancy register,
  // so downstream ready never reaches the FIFO pointer logic.
  assign rincr_o = rrst_n & ~flush_i & ~rempty_i & (occ_q != RD_OCC_FULL);
  assign push    = rincr_o;
  // A pop offered during flush is dropped along with the buffer contents.
  assign pop     = m_valid_o & m_ready_i & ~flush_i;

  always_comb begin
    occ_d = occ_q;
    case ({push, pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      mem_q  <= '0;
      wptr_q <= 1'b0;
      rptr_q <= 1'b0;
      occ_q  <= '0;
    end else if (flush_i) begin
      // Buffer data is left in place; it is unreachable once occ is 0.
      wptr_q <= 1'b0;
      rptr_q <= 1'b0;
      occ_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wptr_q] <= rdata_i;
        wptr_q        <= ~wptr_q;
      end
      if (pop) rptr_q <= ~rptr_q;
      occ_q <= occ_d;
    end
  end

  assign m_valid_o = (occ_q != '0);
  assign m_data_o  = mem_q[rptr_q];
  assign occ_o     = occ_q;

`ifdef FIFO_RD_STATS_EN
  fifo_rd_stats u_stats (
    .rclk    (rclk),
    .rrst_n  (rrst_n),
    .hs_i    (m_valid_o & m_ready_i),
    .stall_i (m_valid_o & ~m_ready_i),
    .words_o (words_o),
    .stall_o (stall_o)
  );
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
module tb_fifo_rd_stream;
  import fifo_rd_pkg::*;

  logic        rclk = 1'b0;
  logic        rrst_n = 1'b0;
  logic        rempty_i = 1'b1;
  logic [31:0] rdata_i = '0;
  logic        rincr_o;
  logic        m_valid_o;
  logic [31:0] m_data_o;
  logic        m_ready_i = 1'b0;
  logic        flush_i = 1'b0;
  logic [1:0]  occ_o;
`ifdef FIFO_RD_STATS_EN
  logic [31:0] words_o, stall_o;
`endif

  fifo_rd_stream #(.DATA_LEN(32)) dut (
    .rclk(rclk), .rrst_n(rrst_n), .rempty_i(rempty_i), .rdata_i(rdata_i),
    .rincr_o(rincr_o), .m_valid_o(m_valid_o), .m_data_o(m_data_o),
    .m_ready_i(m_ready_i), .flush_i(flush_i), .occ_o(occ_o)
`ifdef FIFO_RD_STATS_EN
    , .words_o(words_o), .stall_o(stall_o)
`endif
  );

  always #5 rclk = ~rclk;

  int n_cmp = 0;
  int n_err = 0;

  // FIFO model: head is fifo_q[0]; popped on the edge closing a rincr_o cycle.
  logic [31:0] fifo_q[$];
  logic [31:0] exp_q[$];

  // Per-cycle samples of the DUT outputs (taken mid-low-phase, before the edge).
  logic        s_rincr, s_valid;
  logic [31:0] s_data;
  logic [1:0]  s_occ;

  task automatic cyc();
    rempty_i = (fifo_q.size() == 0);
    rdata_i  = rempty_i ? 32'h0 : fifo_q[0];
    #1;
    s_rincr = rincr_o;
    s_valid = m_valid_o;
    s_data  = m_data_o;
    s_occ   = occ_o;
    n_cmp++;
    if (s_rincr && rempty_i) begin
      n_err++;
      if (n_err < 30) $display("FAIL rincr_on_empty: rincr_o=%0b with rempty_i=1 at %0t", s_rincr, $time);
    end
    @(posedge rclk);
    if (s_rincr && fifo_q.size() != 0) fifo_q.delete(0);
    @(negedge rclk);
  endtask

  task automatic do_reset();
    rrst_n = 1'b0;
    flush_i = 1'b0;
    m_ready_i = 1'b0;
    fifo_q.delete();
    cyc(); cyc();
    rrst_n = 1'b1;
  endtask

  task automatic test_reset();
    rrst_n = 1'b0;
    cyc(); cyc();
    // FIFO holds data while in reset: still no pop.
    fifo_q.push_back(32'hDEAD_BEEF);
    cyc();
    n_cmp++; if (s_rincr !== 1'b0) begin n_err++; $display("FAIL reset_rincr: got %0b want 0", s_rincr); end
    n_cmp++; if (s_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %0b want 0", s_valid); end
    n_cmp++; if (s_occ !== 2'd0) begin n_err++; $display("FAIL reset_occ: got %0d want 0", s_occ); end
    n_cmp++; if (s_data !== 32'h0) begin n_err++; $display("FAIL reset_data: got %h want 0", s_data); end
    fifo_q.delete();
    rrst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      n_cmp++;
      if (s_rincr !== 1'b0 || s_valid !== 1'b0 || s_occ !== 2'd0) begin
        n_err++;
        $display("FAIL idle_empty: cyc %0d rincr=%0b valid=%0b occ=%0d want 0/0/0", i, s_rincr, s_valid, s_occ);
      end
    end
  endtask

  task automatic test_stream();
    logic        r_rincr[20];
    logic        r_valid[20];
    logic [31:0] r_data[20];
    int fr, fv;
    for (int k = 0; k < 8; k++) fifo_q.push_back(32'h11 + k);
    m_ready_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc();
      r_rincr[i] = s_rincr; r_valid[i] = s_valid; r_data[i] = s_data;
    end
    fr = -1; fv = -1;
    for (int i = 19; i >= 0; i--) begin
      if (r_rincr[i]) fr = i;
      if (r_valid[i]) fv = i;
    end
    n_cmp++;
    if (fr < 0 || fv != fr + 1) begin
      n_err++; $display("FAIL stream_latency: first valid cyc %0d, want %0d", fv, fr + 1);
    end else begin
      for (int k = 0; k < 8; k++) begin
        n_cmp++;
        if (r_valid[fv+k] !== 1'b1 || r_data[fv+k] !== 32'h11 + k) begin
          n_err++;
          $display("FAIL stream_word%0d: valid=%0b data=%h want 1/%h", k, r_valid[fv+k], r_data[fv+k], 32'h11 + k);
        end
      end
      n_cmp++;
      if (r_valid[fv+8] !== 1'b0) begin n_err++; $display("FAIL stream_end: valid=%0b want 0", r_valid[fv+8]); end
    end
    m_ready_i = 1'b0;
  endtask

  task automatic test_backpressure();
    int pops = 0;
    int got = 0;
    for (int k = 0; k < 4; k++) fifo_q.push_back(32'h21 + k);
    m_ready_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (s_rincr) pops++;
      if (s_valid) begin
        n_cmp++;
        if (s_data !== 32'h21) begin n_err++; $display("FAIL bp_hold_data: got %h want 00000021", s_data); end
      end
    end
    n_cmp++; if (pops != 2) begin n_err++; $display("FAIL bp_pops: got %0d want 2", pops); end
    n_cmp++; if (s_occ !== 2'd2) begin n_err++; $display("FAIL bp_occ: got %0d want 2", s_occ); end
    n_cmp++; if (s_rincr !== 1'b0) begin n_err++; $display("FAIL bp_rincr: got %0b want 0", s_rincr); end
    m_ready_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (s_valid) begin
        n_cmp++;
        if (got >= 4 || s_data !== 32'h21 + got) begin
          n_err++; $display("FAIL bp_resume%0d: got %h want %h", got, s_data, 32'h21 + got);
        end
        got++;
      end
    end
    n_cmp++; if (got != 4) begin n_err++; $display("FAIL bp_count: got %0d want 4", got); end
    m_ready_i = 1'b0;
  endtask

  task automatic test_flush();
    int got = 0;
    fifo_q.push_back(32'hA); fifo_q.push_back(32'hB); fifo_q.push_back(32'hC);
    m_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) cyc();
    n_cmp++; if (s_occ !== 2'd2) begin n_err++; $display("FAIL flush_pre_occ: got %0d want 2", s_occ); end
    flush_i = 1'b1;
    m_ready_i = 1'b1;   // pop offered during flush must be ignored
    cyc();
    n_cmp++; if (s_rincr !== 1'b0) begin n_err++; $display("FAIL flush_rincr: got %0b want 0", s_rincr); end
    flush_i = 1'b0;
    cyc();
    n_cmp++;
    if (s_valid !== 1'b0 || s_occ !== 2'd0) begin
      n_err++; $display("FAIL flush_post: valid=%0b occ=%0d want 0/0", s_valid, s_occ);
    end
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (s_valid) begin
        n_cmp++;
        if (got != 0 || s_data !== 32'hC) begin n_err++; $display("FAIL flush_deliver%0d: got %h want 0000000c", got, s_data); end
        got++;
      end
    end
    n_cmp++; if (got != 1) begin n_err++; $display("FAIL flush_count: got %0d want 1", got); end
    m_ready_i = 1'b0;
  endtask

  task automatic test_random();
    int written = 0, popped = 0, delivered = 0, occ_m, ncyc = 0;
    logic        fe;
    logic [31:0] w;
    exp_q.delete();
    while (delivered < 10000 && ncyc < 60000) begin
      if (written < 10000 && ($urandom % 4) != 0) begin
        w = $urandom;
        fifo_q.push_back(w);
        exp_q.push_back(w);
        written++;
      end
      m_ready_i = $urandom % 2;
      occ_m = popped - delivered;
      fe = (fifo_q.size() == 0);
      cyc();
      ncyc++;
      n_cmp++;
      if (s_occ !== 2'(occ_m) || s_valid !== (occ_m != 0) || s_rincr !== (!fe && occ_m != 2)) begin
        n_err++;
        if (n_err < 30)
          $display("FAIL rnd_ctrl: cyc %0d occ=%0d valid=%0b rincr=%0b want %0d/%0b/%0b",
                   ncyc, s_occ, s_valid, s_rincr, occ_m, occ_m != 0, !fe && occ_m != 2);
      end
      if (s_rincr) popped++;
      if (s_valid && m_ready_i) begin
        n_cmp++;
        if (exp_q.size() == 0 || s_data !== exp_q[0]) begin
          n_err++;
          if (n_err < 30) $display("FAIL rnd_data: word %0d got %h want %h", delivered, s_data,
                                   exp_q.size() != 0 ? exp_q[0] : 32'hX);
        end
        if (exp_q.size() != 0) exp_q.delete(0);
        delivered++;
      end
    end
    n_cmp++;
    if (delivered != 10000) begin n_err++; $display("FAIL rnd_budget: delivered %0d want 10000", delivered); end
    m_ready_i = 1'b0;
  endtask

`ifdef FIFO_RD_STATS_EN
  task automatic test_stats();
    logic [31:0] v;
    do_reset();
    for (int k = 0; k < 5; k++) fifo_q.push_back(32'h51 + k);
    // cycle 0: pop, nothing valid yet; cycles 1..3: valid held -> 3 stalls
    for (int i = 0; i < 4; i++) cyc();
    m_ready_i = 1'b1;
    for (int i = 0; i < 10; i++) cyc();
    m_ready_i = 1'b0;
    n_cmp++; if (words_o !== 32'd5) begin n_err++; $display("FAIL stats_words: got %0d want 5", words_o); end
    n_cmp++; if (stall_o !== 32'd3) begin n_err++; $display("FAIL stats_stall: got %0d want 3", stall_o); end
    v = 32'hFFFF_FFFE;
    for (int i = 0; i < 3; i++) v = sat_inc(v);
    n_cmp++; if (v !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL stats_sat: got %h want ffffffff", v); end
  endtask
`endif

  initial begin
    @(negedge rclk);
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_random();
`ifdef FIFO_RD_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
